pulse_xfer_arbiter: RTL and testbench
=====================================

# pulse_xfer_arbiter

Source-domain scheduler that shares a single four-phase req/ack pulse-synchronizer channel among `N_REQ` requesters. It latches each requester's single-cycle event pulses into pending bits and grants the channel round-robin. It runs one full handshake per grant and reports completion and dropped events. It sits between event producers and the pulse-transfer synchronizer, all in the producers' clock domain.

## Interface
- `N_REQ`, 4: number of requesters (2..16).
- `ID_W`, $clog2(N_REQ): width of `xfer_id`.
- `CNT_W`, 8: width of the dropped-event counter.

- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `evt_in`  in  N_REQ  per-requester event; each high cycle is one event.
- `xfer_ack`  in  1  handshake ack from the synchronizer, already synchronized into `clk`.
- `drop_clr`  in  1  synchronous clear of `drop_cnt`.
- `xfer_req`  out  1  handshake request level to the synchronizer.
- `xfer_id`  out  ID_W  index of the requester being transferred; valid while `busy`.
- `pend`  out  N_REQ  registered pending bits.
- `done`  out  N_REQ  one-cycle pulse on the granted bit when its handshake completes.
- `busy`  out  1  high in states REQ and REL.
- `drop_cnt`  out  CNT_W  saturating count of dropped events.

## Operation
- The reset value of every output is 0. The round-robin pointer `last` resets to N_REQ-1, so requester 0 has first priority. `rst` during any state aborts the handshake immediately with no `done`.
- **Pending:** `pend[i]` sets on `evt_in[i]=1`. It clears in the cycle its grant is taken (IDLE->REQ). If `evt_in[i]` and the clear happen in the same cycle, `pend[i]` stays 1.
- **Drop:** a drop occurs when `evt_in[i]=1` while `pend[i]=1` and `pend[i]` is not being cleared that cycle.
  - Each cycle, `drop_cnt` adds the popcount of drops and saturates at 2^CNT_W-1.
  - `drop_clr` loads `drop_cnt` with that cycle's drop popcount, so clear and drops in the same cycle are not lost.
- **FSM states:**
  - IDLE: `xfer_req`=0. If `pend`≠0 and `xfer_ack`=0, select the first set `pend` bit searching from `last`+1 with wrap. Register it into `xfer_id`, set `last`=id, clear its `pend` bit, go to REQ. If `xfer_ack`=1 in IDLE (stale ack), stay in IDLE.
  - REQ: `xfer_req`=1, `xfer_id` held. Go to REL when `xfer_ack`=1.
  - REL: `xfer_req`=0, `xfer_id` held. When `xfer_ack`=0, pulse `done[xfer_id]` and go to IDLE.
- `xfer_id` is stable from IDLE->REQ until the REL->IDLE transition and holds its last value in IDLE.
- The handshake has no timeout. The block waits indefinitely in REQ or REL.

## Timing
- `evt_in[i]` high in cycle t gives `pend[i]`=1 in t+1. With the channel idle, `xfer_req` rises in t+2.
- `xfer_ack` first seen high in cycle k gives `xfer_req`=0 in k+1.
- `xfer_ack` first seen low in REL in cycle m gives `done[id]` high in cycle m+1 only, with the state back in IDLE. The next grant is taken in that same cycle, so the next `xfer_req` rises in m+2.
- Throughput is at most one transfer per (ack rise latency + ack fall latency + 2) cycles.
- `pend` is set at most once per requester while outstanding. Events for a requester already in flight re-pend it (one extra transfer), not a drop.

## Test plan
- **Single event:** reset, `evt_in`=4'b0100 for 1 cycle, ack rises 3 cycles after `xfer_req` and falls 3 cycles after the drop.
  - Required: `xfer_req` rises in t+2 with `xfer_id`=2 and `done`=4'b0100 exactly once.
  - `drop_cnt`=0 and `pend`=0 at the end.
- **Round-robin:** `evt_in`=4'b1111 for 1 cycle.
  - Required: grant order 0,1,2,3.
  - Then pulse requesters 0 and 3 together: order 0,3.
  - Then pulse requesters 3 and 0 after a grant to 3: order 0,3 (search starts from `last`+1).
- **Drops and saturation:** with CNT_W=2, hold `evt_in[1]`=1 for 6 cycles while requester 0 is in REQ.
  - Required: `drop_cnt` counts 1,2,3,3 and `pend[1]`=1.
  - `drop_clr` together with one drop gives `drop_cnt`=1.
- **Re-pend during transfer:** pulse `evt_in[2]` while `xfer_id`=2 is in REQ.
  - Required: no drop, `pend[2]`=1, and a second transfer with id 2 follows after `done`.
- **Stale ack and mid-operation reset:**
  - Hold `xfer_ack`=1 from reset with `pend[0]`=1. Required: no `xfer_req` until ack falls.
  - Assert `rst` while in REQ. Required: all outputs 0 asynchronously, no `done`, and first priority back at requester 0.

Source files
------------

// File: rtl/pulse_xfer_arbiter.sv
// pulse_xfer_arbiter: round-robin scheduler sharing one four-phase req/ack pulse channel among N_REQ event sources
module pulse_xfer_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] evt_in_i,
    input  logic             xfer_ack_i,
    input  logic             drop_clr_i,
    output logic             xfer_req_o,
    output logic [ID_W-1:0]  xfer_id_o,
    output logic [N_REQ-1:0] pend_o,
    output logic [N_REQ-1:0] done_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] drop_cnt_o
);
    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
    state_t state_q, state_d;
    logic [ID_W-1:0] id_q, id_d, last_q, last_d, sel;
    logic [N_REQ-1:0] pend_q, pend_d, done_q, done_d, clr, drop;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W+4:0] sum;
    logic [ID_W:0] idx;
    logic [4:0] pop;
    logic found;
    // first set pending bit searching upward from last+1, wrapping at N_REQ
    always_comb begin
        sel = '0;
        found = 1'b0;
        idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = {1'b0, last_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
            if (!found && pend_q[idx[ID_W-1:0]]) begin
                found = 1'b1;
                sel = idx[ID_W-1:0];
            end
        end
    end
    always_comb begin
        state_d = state_q;
        id_d = id_q;
        last_d = last_q;
        done_d = '0;
        clr = '0;
        case (state_q)
            IDLE: if (|pend_q && !xfer_ack_i) begin
                state_d = REQ;
                id_d = sel;
                last_d = sel;
                clr[sel] = 1'b1;
            end
            REQ: if (xfer_ack_i) state_d = REL;
            REL: if (!xfer_ack_i) begin
                state_d = IDLE;
                done_d[id_q] = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // an event arriving on the cycle its bit is granted re-pends rather than drops
    always_comb begin
        drop = evt_in_i & pend_q & ~clr;
        pop = '0;
        for (int i = 0; i < N_REQ; i++) pop = pop + 5'(drop[i]);
        sum = (drop_clr_i ? '0 : (CNT_W+5)'(cnt_q)) + (CNT_W+5)'(pop);
        cnt_d = |sum[CNT_W+4:CNT_W] ? '1 : sum[CNT_W-1:0];
        pend_d = (pend_q & ~clr) | evt_in_i;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q <= '0;
            last_q <= ID_W'(N_REQ-1);
            pend_q <= '0;
            done_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            id_q <= id_d;
            last_q <= last_d;
            pend_q <= pend_d;
            done_q <= done_d;
            cnt_q <= cnt_d;
        end
    end
    assign xfer_req_o = state_q == REQ;
    assign busy_o = state_q != IDLE;
    assign xfer_id_o = id_q;
    assign pend_o = pend_q;
    assign done_o = done_q;
    assign drop_cnt_o = cnt_q;
endmodule

// File: tb/tb_pulse_xfer_arbiter.sv
// tb_pulse_xfer_arbiter: directed checks of grant order, handshake timing, drop counting and reset
module tb_pulse_xfer_arbiter;
    logic clk, rst, xfer_ack, drop_clr, xfer_req, busy;
    logic [3:0] evt, pend, done;
    logic [1:0] xfer_id, drop_cnt;
    int n_cmp = 0, n_bad = 0;

    pulse_xfer_arbiter #(.N_REQ(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .evt_in_i(evt), .xfer_ack_i(xfer_ack), .drop_clr_i(drop_clr),
        .xfer_req_o(xfer_req), .xfer_id_o(xfer_id), .pend_o(pend), .done_o(done),
        .busy_o(busy), .drop_cnt_o(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ack);
        rst = 1'b1; evt = '0; xfer_ack = ack; drop_clr = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    // entered in the cycle xfer_req is expected high; returns in the done cycle
    task automatic hs(input int id);
        chk("hs_req", xfer_req, 1);
        chk("hs_id", xfer_id, id);
        chk("hs_nodone", done, 0);
        xfer_ack = 1'b1;
        step();
        chk("rel_req", xfer_req, 0);
        chk("rel_busy", busy, 1);
        chk("rel_id", xfer_id, id);
        xfer_ack = 1'b0;
        step();
        chk("done", done, 32'd1 << id);
        chk("done_busy", busy, 0);
    endtask

    initial begin
        do_reset(1'b0);
        chk("rst_req", xfer_req, 0); chk("rst_pend", pend, 0); chk("rst_done", done, 0);
        chk("rst_busy", busy, 0); chk("rst_id", xfer_id, 0); chk("rst_cnt", drop_cnt, 0);

        // single event with 3-cycle ack latencies
        evt = 4'b0100; step(); evt = '0;
        chk("s_pend", pend, 4'b0100); chk("s_req_t1", xfer_req, 0);
        step();
        chk("s_req_t2", xfer_req, 1); chk("s_id", xfer_id, 2); chk("s_pend0", pend, 0);
        step(); step(); step();
        chk("s_hold", xfer_req, 1);
        xfer_ack = 1'b1; step();
        chk("s_drop", xfer_req, 0); chk("s_busy", busy, 1);
        step(); step(); step();
        chk("s_nodone", done, 0);
        xfer_ack = 1'b0; step();
        chk("s_done", done, 4'b0100); chk("s_idle", busy, 0);
        step();
        chk("s_done_once", done, 0); chk("s_end_pend", pend, 0); chk("s_end_cnt", drop_cnt, 0);

        // round robin from reset: 0,1,2,3
        do_reset(1'b0);
        evt = 4'b1111; step(); evt = '0;
        chk("rr_pend", pend, 4'b1111);
        step(); hs(0);
        step(); hs(1);
        step(); hs(2);
        step(); hs(3);
        step(); chk("rr_idle", busy, 0); chk("rr_done_clr", done, 0);
        evt = 4'b1001; step(); evt = '0;
        step(); hs(0);
        step(); hs(3);
        // 0 and 3 pended while 3 is in flight: search restarts at 0
        step();
        evt = 4'b1000; step(); evt = '0;
        step(); chk("rr3_id", xfer_id, 3);
        evt = 4'b1001; step(); evt = '0;
        chk("rr3_pend", pend, 4'b1001); chk("rr3_cnt", drop_cnt, 0);
        hs(3);
        step(); hs(0);
        step(); hs(3);

        // drops and 2-bit saturation while requester 0 sits in REQ
        do_reset(1'b0);
        evt = 4'b0001; step(); evt = '0;
        step(); chk("d_req", xfer_req, 1); chk("d_id", xfer_id, 0);
        evt = 4'b0010;
        step(); chk("d_cnt0", drop_cnt, 0);
        step(); chk("d_cnt1", drop_cnt, 1);
        step(); chk("d_cnt2", drop_cnt, 2);
        step(); chk("d_cnt3", drop_cnt, 3);
        step(); chk("d_sat1", drop_cnt, 3);
        step(); chk("d_sat2", drop_cnt, 3);
        evt = '0;
        chk("d_pend1", pend, 4'b0010);
        evt = 4'b0010; drop_clr = 1'b1; step(); evt = '0; drop_clr = 1'b0;
        chk("d_clr", drop_cnt, 1);
        hs(0);
        step(); hs(1);
        chk("d_cnt_keep", drop_cnt, 1);

        // re-pend of the requester in flight
        step();
        evt = 4'b0100; step(); evt = '0;
        step(); chk("rp_id", xfer_id, 2);
        evt = 4'b0100; step(); evt = '0;
        chk("rp_pend", pend, 4'b0100); chk("rp_nodrop", drop_cnt, 1);
        hs(2);
        step(); hs(2);
        step(); chk("rp_pend0", pend, 0);

        // stale ack held from reset blocks the grant
        do_reset(1'b1);
        evt = 4'b0101; step(); evt = '0;
        step(); step();
        chk("st_noreq", xfer_req, 0); chk("st_busy", busy, 0); chk("st_pend", pend, 4'b0101);
        xfer_ack = 1'b0; step();
        chk("st_req", xfer_req, 1); chk("st_id", xfer_id, 0);
        hs(0);
        step(); chk("st_id2", xfer_id, 2);

        // async reset mid-REQ with pending work and a nonzero drop count
        evt = 4'b1000; step(); step(); evt = '0;
        chk("ar_pre_cnt", drop_cnt, 1); chk("ar_pre_pend", pend, 4'b1000);
        #2 rst = 1'b1; #1;
        chk("ar_req", xfer_req, 0); chk("ar_busy", busy, 0); chk("ar_pend", pend, 0);
        chk("ar_id", xfer_id, 0); chk("ar_cnt", drop_cnt, 0); chk("ar_done", done, 0);
        step(); chk("ar_done2", done, 0);
        rst = 1'b0;
        evt = 4'b1001; step(); evt = '0;
        step(); chk("ar_prio", xfer_id, 0); chk("ar_req2", xfer_req, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
